// File: rtl/fifo_burst_reader.sv
// Drains a synchronous FIFO in bursts onto a valid/ready stream with first/last markers.
// A 2-entry output buffer absorbs the FIFO's one-cycle read latency under backpressure.
module fifo_burst_reader #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 4,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] fifo_out,
    input  logic              fifo_empty,
    input  logic [AWIDTH:0]   fifo_num,
    output logic              fifo_pop,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_first,
    output logic              m_last,
    output logic              busy
);
    localparam int CW = AWIDTH + 1;
    localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] BURST_LEN = CW'(BURST);
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);
    localparam bit            TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    typedef struct packed {
        logic              first;
        logic              last;
        logic [DWIDTH-1:0] data;
    } word_t;

    state_t        state, state_n;
    logic [CW-1:0] len, popped, sent;
    logic [IW-1:0] idle_cnt;
    logic          inflight, inflight_first, inflight_last;
    word_t         obuf [2];
    logic [1:0]    buf_occ, occ_sum;
    logic          start, deq, wr_idx;
    logic [CW-1:0] start_len;

    assign busy     = (state == S_BURST);
    assign m_valid  = (buf_occ != 2'd0);
    assign m_data   = obuf[0].data;
    assign m_first  = m_valid && obuf[0].first;
    assign m_last   = m_valid && obuf[0].last;
    assign deq      = m_valid && m_ready;
    // Words already popped but not yet delivered must fit in the buffer.
    assign occ_sum  = buf_occ + {1'b0, inflight};
    assign fifo_pop = busy && (popped < len) && !fifo_empty && (occ_sum < 2'd2);
    // Arriving word lands behind whatever survives this cycle's dequeue.
    assign wr_idx   = (buf_occ == 2'd2) || ((buf_occ == 2'd1) && !deq);

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        start_len = len;
        case (state)
            S_IDLE: begin
                if (fifo_num >= BURST_LEN) begin
                    start     = 1'b1;
                    start_len = BURST_LEN;
                end else if (TIMEOUT_EN && !fifo_empty && (idle_cnt == IDLE_LAST)) begin
                    start     = 1'b1;
                    start_len = fifo_num;
                end
                if (start) state_n = S_BURST;
            end
            S_BURST: begin
                if (deq && (sent == len - ONE)) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            len            <= '0;
            popped         <= '0;
            sent           <= '0;
            idle_cnt       <= '0;
            inflight       <= 1'b0;
            inflight_first <= 1'b0;
            inflight_last  <= 1'b0;
            buf_occ        <= 2'd0;
            obuf[0]        <= '0;
            obuf[1]        <= '0;
        end else begin
            state <= state_n;

            if (start) begin
                len    <= start_len;
                popped <= '0;
                sent   <= '0;
            end else begin
                if (fifo_pop) popped <= popped + ONE;
                if (deq)      sent   <= sent + ONE;
            end

            if ((state != S_IDLE) || start || fifo_empty) idle_cnt <= '0;
            else if (idle_cnt != '1)                      idle_cnt <= idle_cnt + IDLE_ONE;

            // Burst position is known at pop time; it travels with the word.
            inflight       <= fifo_pop;
            inflight_first <= (popped == '0);
            inflight_last  <= (popped == len - ONE);

            if (deq)      obuf[0]      <= obuf[1];
            if (inflight) obuf[wr_idx] <= {inflight_first, inflight_last, fifo_out};
            buf_occ <= buf_occ + {1'b0, inflight} - {1'b0, deq};
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Three reader configurations fed by queue-model FIFOs; a burst-level model checks every cycle.
module tb_fifo_burst_reader;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int N     = 3;
    localparam int DEPTH = 1 << AW;
    localparam int LOGN  = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset      [N];
    logic [DW-1:0] fifo_out   [N];
    logic          fifo_empty [N];
    logic [AW:0]   fifo_num   [N];
    logic          fifo_pop   [N];
    logic [DW-1:0] m_data     [N];
    logic          m_valid    [N];
    logic          m_ready    [N];
    logic          m_first    [N];
    logic          m_last     [N];
    logic          busy       [N];

    // inst0: BURST=4 TIMEOUT=8, inst1: BURST=4 TIMEOUT=0, inst2: BURST=1 TIMEOUT=8
    for (genvar g = 0; g < N; g++) begin : g_dut
        fifo_burst_reader #(
            .DWIDTH (DW),
            .AWIDTH (AW),
            .BURST  ((g == 2) ? 1 : 4),
            .TIMEOUT((g == 1) ? 0 : 8)
        ) dut (
            .clk       (clk),
            .reset     (reset[g]),
            .fifo_out  (fifo_out[g]),
            .fifo_empty(fifo_empty[g]),
            .fifo_num  (fifo_num[g]),
            .fifo_pop  (fifo_pop[g]),
            .m_data    (m_data[g]),
            .m_valid   (m_valid[g]),
            .m_ready   (m_ready[g]),
            .m_first   (m_first[g]),
            .m_last    (m_last[g]),
            .busy      (busy[g])
        );
    end

    function automatic int burst_of(input int g);
        return (g == 2) ? 1 : 4;
    endfunction

    function automatic int timeout_of(input int g);
        return (g == 1) ? 0 : 8;
    endfunction

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [N][DEPTH];
    int            head [N], cnt [N];
    bit            push_req [N];
    logic [DW-1:0] push_data [N];
    logic [DW-1:0] exp_q [N][LOGN];
    int            exp_wr [N], exp_rd [N];
    bit            in_b [N];
    int            len [N], sent [N], idle [N], outst [N], popped_b [N];
    bit            prev_rst [N], prev_stall [N];
    logic [DW-1:0] s_data [N];
    logic          s_first [N], s_last [N];
    int            acc_n [N];
    logic [DW-1:0] acc_d [N][LOGN];
    bit            acc_f [N][LOGN], acc_l [N][LOGN];
    int            pop_total [N], valid_total [N];

    task automatic chk_eq(input string name, input int g, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s [inst %0d] t=%0t: got %0d, expected %0d", name, g, $time, act, req);
        end
    endtask

    task automatic model_clear(input int g);
        in_b[g] = 0; len[g] = 0; sent[g] = 0; idle[g] = 0; outst[g] = 0; popped_b[g] = 0;
        prev_stall[g] = 0;
        exp_rd[g] = exp_wr[g];
    endtask

    // One clock: check/advance the model at the negedge, then update the FIFO models after the edge.
    task automatic tick();
        bit do_pop [N];
        bit was_in;
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            do_pop[g] = fifo_pop[g];
            if (prev_rst[g]) begin
                chk_eq("rst_m_valid", g, m_valid[g], 0);
                chk_eq("rst_fifo_pop", g, fifo_pop[g], 0);
                chk_eq("rst_busy", g, busy[g], 0);
                chk_eq("rst_m_data", g, m_data[g], 0);
                chk_eq("rst_m_first", g, m_first[g], 0);
                chk_eq("rst_m_last", g, m_last[g], 0);
            end
            prev_rst[g] = reset[g];
            if (reset[g]) begin
                model_clear(g);
                continue;
            end
            was_in = in_b[g];
            chk_eq("busy", g, busy[g], was_in);
            chk_eq("outstanding_le2", g, outst[g] <= 2, 1);
            if (m_valid[g]) begin
                valid_total[g]++;
                chk_eq("valid_in_burst", g, was_in, 1);
            end
            if (prev_stall[g]) begin
                chk_eq("stall_valid", g, m_valid[g], 1);
                chk_eq("stall_data", g, m_data[g], s_data[g]);
                chk_eq("stall_first", g, m_first[g], s_first[g]);
                chk_eq("stall_last", g, m_last[g], s_last[g]);
            end
            if (fifo_pop[g]) begin
                chk_eq("pop_not_empty", g, fifo_empty[g], 0);
                chk_eq("pop_in_burst", g, was_in, 1);
                chk_eq("pop_within_len", g, popped_b[g] < len[g], 1);
                popped_b[g]++;
                outst[g]++;
                pop_total[g]++;
            end
            if (m_valid[g] && m_ready[g]) begin
                chk_eq("word_expected", g, exp_rd[g] < exp_wr[g], 1);
                if (exp_rd[g] < exp_wr[g]) begin
                    chk_eq("m_data", g, m_data[g], exp_q[g][exp_rd[g]]);
                    exp_rd[g]++;
                end
                chk_eq("m_first", g, m_first[g], sent[g] == 0);
                chk_eq("m_last", g, m_last[g], sent[g] == len[g] - 1);
                if (acc_n[g] < LOGN) begin
                    acc_d[g][acc_n[g]] = m_data[g];
                    acc_f[g][acc_n[g]] = m_first[g];
                    acc_l[g][acc_n[g]] = m_last[g];
                    acc_n[g]++;
                end
                sent[g]++;
                outst[g]--;
                if (was_in && sent[g] == len[g]) in_b[g] = 0;
            end
            if (!was_in) begin
                if (int'(fifo_num[g]) >= burst_of(g)) begin
                    in_b[g] = 1; len[g] = burst_of(g); sent[g] = 0; popped_b[g] = 0; idle[g] = 0;
                end else if (fifo_empty[g]) begin
                    idle[g] = 0;
                end else if (timeout_of(g) != 0 && idle[g] == timeout_of(g) - 1) begin
                    in_b[g] = 1; len[g] = int'(fifo_num[g]); sent[g] = 0; popped_b[g] = 0; idle[g] = 0;
                end else begin
                    idle[g]++;
                end
            end
            prev_stall[g] = m_valid[g] && !m_ready[g];
            s_data[g]  = m_data[g];
            s_first[g] = m_first[g];
            s_last[g]  = m_last[g];
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            if (reset[g]) begin
                head[g] = 0; cnt[g] = 0;
            end else begin
                if (do_pop[g] && cnt[g] > 0) begin
                    fifo_out[g] = mem[g][head[g]];
                    head[g] = (head[g] + 1) % DEPTH;
                    cnt[g]--;
                end
                if (push_req[g] && cnt[g] < DEPTH && exp_wr[g] < LOGN) begin
                    mem[g][(head[g] + cnt[g]) % DEPTH] = push_data[g];
                    cnt[g]++;
                    exp_q[g][exp_wr[g]] = push_data[g];
                    exp_wr[g]++;
                end
            end
            push_req[g]   = 0;
            fifo_num[g]   = (AW + 1)'(cnt[g]);
            fifo_empty[g] = (cnt[g] == 0);
        end
    endtask

    task automatic push(input int g, input int d);
        push_req[g]  = 1;
        push_data[g] = DW'(d);
        tick();
    endtask

    function automatic bit idle_ok(input int g, input bit allow_residue);
        return !in_b[g] && outst[g] == 0 &&
               (cnt[g] == 0 || (allow_residue && cnt[g] < burst_of(g)));
    endfunction

    task automatic wait_idle(input int g, input int budget, input bit allow_residue);
        int n;
        n = 0;
        while (!idle_ok(g, allow_residue) && n < budget) begin
            tick();
            n++;
        end
        chk_eq("drain_in_budget", g, idle_ok(g, allow_residue), 1);
    endtask

    initial begin
        int s, ne, vt, pt;
        for (int g = 0; g < N; g++) begin
            reset[g] = 1; m_ready[g] = 1; fifo_out[g] = '0; fifo_empty[g] = 1; fifo_num[g] = '0;
            head[g] = 0; cnt[g] = 0; push_req[g] = 0; push_data[g] = '0;
            exp_wr[g] = 0; exp_rd[g] = 0; acc_n[g] = 0; pop_total[g] = 0; valid_total[g] = 0;
            prev_rst[g] = 0;
            model_clear(g);
        end
        tick();
        tick();
        for (int g = 0; g < N; g++) reset[g] = 0;
        tick();

        // Two full bursts: 0..3 and 4..7
        s = acc_n[0];
        for (int i = 0; i < 8; i++) push(0, i);
        wait_idle(0, 100, 0);
        chk_eq("t1_count", 0, acc_n[0] - s, 8);
        for (int i = 0; i < 8; i++) begin
            chk_eq("t1_data", 0, acc_d[0][s + i], i);
            chk_eq("t1_first", 0, acc_f[0][s + i], (i % 4) == 0);
            chk_eq("t1_last", 0, acc_l[0][s + i], (i % 4) == 3);
        end

        // Residue of 3 flushed after 8 non-empty idle cycles
        s = acc_n[0];
        ne = 0;
        for (int i = 0; i < 3; i++) begin
            push(0, i);
            if (!busy[0] && !fifo_empty[0]) ne++;
        end
        for (int i = 0; i < 30 && !busy[0]; i++) begin
            tick();
            if (!busy[0] && !fifo_empty[0]) ne++;
        end
        chk_eq("t2_idle_cycles", 0, ne, 8);
        wait_idle(0, 100, 0);
        chk_eq("t2_count", 0, acc_n[0] - s, 3);
        for (int i = 0; i < 3; i++) begin
            chk_eq("t2_data", 0, acc_d[0][s + i], i);
            chk_eq("t2_first", 0, acc_f[0][s + i], i == 0);
            chk_eq("t2_last", 0, acc_l[0][s + i], i == 2);
        end

        // Alternating backpressure
        s = acc_n[0];
        for (int i = 0; i < 16; i++) begin
            m_ready[0] = (i % 2) == 0;
            push(0, i);
        end
        for (int i = 0; i < 200 && !idle_ok(0, 0); i++) begin
            m_ready[0] = (i % 2) == 0;
            tick();
        end
        m_ready[0] = 1;
        wait_idle(0, 50, 0);
        chk_eq("t3_count", 0, acc_n[0] - s, 16);
        for (int i = 0; i < 16; i++) chk_eq("t3_data", 0, acc_d[0][s + i], i);

        // Reset in the middle of a burst
        s = acc_n[0];
        for (int i = 0; i < 4; i++) push(0, 10 + i);
        for (int i = 0; i < 40 && acc_n[0] < s + 2; i++) tick();
        chk_eq("t4_two_accepted", 0, acc_n[0] - s, 2);
        reset[0] = 1;
        tick();
        reset[0] = 0;
        chk_eq("t4_busy", 0, busy[0], 0);
        chk_eq("t4_m_valid", 0, m_valid[0], 0);
        chk_eq("t4_fifo_pop", 0, fifo_pop[0], 0);
        vt = valid_total[0];
        pt = pop_total[0];
        repeat (20) tick();
        chk_eq("t4_no_valid", 0, valid_total[0], vt);
        chk_eq("t4_no_pop", 0, pop_total[0], pt);
        s = acc_n[0];
        for (int i = 0; i < 4; i++) push(0, 20 + i);
        wait_idle(0, 100, 0);
        chk_eq("t4_new_count", 0, acc_n[0] - s, 4);
        chk_eq("t4_new_first_word", 0, acc_d[0][s], 20);

        // Flush disabled: residue waits until a full burst exists
        for (int i = 0; i < 3; i++) push(1, i);
        repeat (100) tick();
        chk_eq("t5_no_pop", 1, pop_total[1], 0);
        chk_eq("t5_no_valid", 1, valid_total[1], 0);
        push(1, 3);
        wait_idle(1, 100, 0);
        chk_eq("t5_count", 1, acc_n[1], 4);
        for (int i = 0; i < 4; i++) begin
            chk_eq("t5_data", 1, acc_d[1][i], i);
            chk_eq("t5_first", 1, acc_f[1][i], i == 0);
            chk_eq("t5_last", 1, acc_l[1][i], i == 3);
        end

        // Single-word bursts
        for (int i = 0; i < 5; i++) push(2, 50 + i);
        wait_idle(2, 100, 0);
        chk_eq("t6_count", 2, acc_n[2], 5);
        for (int i = 0; i < 5; i++) begin
            chk_eq("t6_data", 2, acc_d[2][i], 50 + i);
            chk_eq("t6_first_last", 2, acc_f[2][i] && acc_l[2][i], 1);
        end

        // Randomized traffic and backpressure on all configurations
        repeat (1200) begin
            for (int g = 0; g < N; g++) begin
                m_ready[g] = ($urandom_range(9, 0) < 7);
                if ($urandom_range(1, 0) == 1 && cnt[g] < DEPTH) begin
                    push_req[g]  = 1;
                    push_data[g] = DW'($urandom);
                end
            end
            tick();
        end
        for (int g = 0; g < N; g++) m_ready[g] = 1;
        wait_idle(0, 300, 0);
        wait_idle(1, 300, 1);
        wait_idle(2, 300, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
